mmap_stats_reader: RTL
======================

Name: mmap_stats_reader

Overview:
- Bus initiator for the memory-mapped stats/timer/button register file: drives mmap_re, mmap_addr and br_stats_wr, and drives or samples the shared 16-bit databus.
- Arbitrates for the bus, sweeps a contiguous register window one read at a time, and emits each captured word on a valid/ready stream toward a debug/UART/display consumer.
- Also issues the stats-enable write (databus[0]) on request, so the counters can be enabled or disabled without the CPU.

Parameters:
- FIRST_ADDR, 4'h0, first mmap register address in a sweep.
- NUM_REGS, 6, registers per sweep (1..16; FIRST_ADDR+NUM_REGS-1 <= 15).
- PERIOD, 1024, cycles between sweep starts in continuous mode (>= 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request for one sweep.
- cont_mode  in  1  1 = sweep automatically every PERIOD cycles.
- stats_ctl_req  in  1  pulse: write stats_ctl_val to the stats-enable register.
- stats_ctl_val  in  1  value for databus[0] on that write.
- bus_req  out  1  request for ownership of mmap_re/mmap_addr/databus.
- bus_gnt  in  1  ownership granted; may drop at any cycle.
- mmap_re  out  1  mmap read strobe.
- mmap_addr  out  4  register address.
- br_stats_wr  out  1  stats-enable write strobe.
- databus  inout  16  shared data bus; driven only during a write.
- out_valid  out  1  captured word available.
- out_ready  in  1  consumer accepts the word.
- out_addr  out  4  address of the captured word.
- out_data  out  16  captured word.
- busy  out  1  FSM not in IDLE.
- sweep_done  out  1  one-cycle pulse after the last word of a sweep is accepted.

Behaviour:
- Reset (async, immediate): all outputs 0, databus Z, FSM IDLE, index = 0, pending-write flag clear, period counter 0.
- FSM states: IDLE, REQ, READ, HOLD, WRITE.
- IDLE:
  - pending write -> REQ (write job). Write has priority over a same-cycle start or period trigger.
  - otherwise start, or (cont_mode and period counter == PERIOD-1) -> REQ (sweep job) with index = 0.
- REQ:
  - bus_req = 1.
  - bus_gnt -> READ for a sweep job, or WRITE for a write job.
- READ (exactly one cycle):
  - mmap_re = 1, mmap_addr = FIRST_ADDR + index.
  - databus sampled at the clock edge ending the cycle into out_data/out_addr.
  - If bus_gnt is high that cycle -> HOLD with out_valid = 1 from the next cycle.
  - If bus_gnt is low: discard the data -> REQ, index unchanged.
- HOLD:
  - bus_req stays 1; mmap_re = 0.
  - out_valid and out_data/out_addr held stable until out_valid & out_ready.
  - On handshake: out_valid deasserts the next cycle.
    - If index == NUM_REGS-1: bus_req drops, sweep_done pulses for one cycle, -> IDLE.
    - Otherwise index++ -> READ if bus_gnt, else REQ.
- WRITE (exactly one cycle):
  - br_stats_wr = 1, databus = {15'b0, stats_ctl_val}, mmap_addr = 0.
  - Must not be entered without bus_gnt.
  - Next state IDLE, pending flag cleared, bus_req dropped.
- databus tristate enable is asserted only in WRITE; Z in every other state and during reset.
- mmap_re and br_stats_wr are never high together and never high without bus_gnt.
- busy = 1 in any state other than IDLE.
- Latency: with bus_gnt already high, start seen in cycle 0 -> REQ in cycle 1, READ in cycle 2, out_valid in cycle 3. Each further word takes 2 cycles if out_ready is held high.
- stats_ctl_req while busy is latched into the pending flag (single-deep; a second request overwrites the value) and serviced after the current sweep.
- start while busy is ignored, not queued.
- Period counter:
  - increments every cycle while cont_mode = 1 and wraps to 0 at PERIOD-1; the trigger fires at that wrap.
  - held at 0 while cont_mode = 0.
  - A trigger that fires while busy is dropped.
- Address arithmetic is 4-bit modulo; parameter legality is checked by an elaboration-time assertion.

Decomposition:
- Shared package mmap_pkg:
  - register address constants: REG_BR_CNT = 4'h0, REG_MISPR_CNT = 4'h1, REG_HIT_CNT = 4'h2, REG_TIMER = 4'h3, REG_KEY_UP = 4'h4, REG_KEY_DOWN = 4'h5, REG_STATS_EN.
  - the reader state enum.
- Sub-module mmap_sweep_timer: PERIOD counter with enable and a trigger pulse output.

Test Plan:
- Basic sweep: gnt tied 1, out_ready 1, model regs hold 16'h0000..16'h0005, start pulse -> out_valid first at cycle 3; six words with out_addr 0..5 and matching data; sweep_done one cycle after the 6th handshake; bus_req low afterward.
- Backpressure: out_ready low for 10 cycles at word 2 -> out_data/out_addr held at addr 2; no mmap_re during the stall; the sweep resumes with addr 3 after the handshake.
- Grant loss: drop bus_gnt during the READ of addr 4 -> data discarded, FSM returns to REQ, mmap_re stays low while gnt is low; on regrant, addr 4 is re-read and no word is duplicated or skipped.
- Stats write: stats_ctl_req with val = 1 while idle and gnt = 1 -> exactly one cycle of br_stats_wr with databus = 16'h0001; databus Z in all other cycles; model stats_en becomes 1.
- Collision: stats_ctl_req (val = 0) in the same cycle as start -> write issued first, then a full sweep; a request mid-sweep is deferred until after sweep_done.
- Continuous mode and reset: PERIOD = 32, cont_mode = 1 -> sweeps start every 32 cycles; rst asserted mid-HOLD -> all outputs 0 and databus Z without waiting for a clock edge; after release no activity until a new trigger.

Source files
------------

// File: rtl/mmap_pkg.sv
// rtl/mmap_pkg.sv - mmap register map constants and stats reader state encoding
package mmap_pkg;

  localparam logic [3:0] REG_BR_CNT    = 4'h0;
  localparam logic [3:0] REG_MISPR_CNT = 4'h1;
  localparam logic [3:0] REG_HIT_CNT   = 4'h2;
  localparam logic [3:0] REG_TIMER     = 4'h3;
  localparam logic [3:0] REG_KEY_UP    = 4'h4;
  localparam logic [3:0] REG_KEY_DOWN  = 4'h5;
  // The enable register is write-only and decoded by br_stats_wr, so it shares address 0.
  localparam logic [3:0] REG_STATS_EN  = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_READ,
    ST_HOLD,
    ST_WRITE
  } rd_state_t;

endpackage

// File: rtl/mmap_sweep_timer.sv
// rtl/mmap_sweep_timer.sv - free-running sweep period counter with a one-cycle trigger
module mmap_sweep_timer #(
  parameter int PERIOD = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic trig
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign trig = en && (cnt == LAST);

endmodule

// File: rtl/mmap_stats_reader.sv
// rtl/mmap_stats_reader.sv - mmap bus initiator: sweeps a register window onto a stream, issues stats-enable writes
module mmap_stats_reader
  import mmap_pkg::*;
#(
  parameter logic [3:0] FIRST_ADDR = 4'h0,
  parameter int         NUM_REGS   = 6,
  parameter int         PERIOD     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cont_mode,
  input  logic        stats_ctl_req,
  input  logic        stats_ctl_val,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        mmap_re,
  output logic [3:0]  mmap_addr,
  output logic        br_stats_wr,
  inout  wire  [15:0] databus,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_addr,
  output logic [15:0] out_data,
  output logic        busy,
  output logic        sweep_done
);

  if (NUM_REGS < 1 || NUM_REGS > 16 || int'(FIRST_ADDR) + NUM_REGS > 16 || PERIOD < 2)
  begin : g_bad_params
    $error("mmap_stats_reader: illegal FIRST_ADDR/NUM_REGS/PERIOD combination");
  end

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  rd_state_t   state, state_nx;
  logic [3:0]  idx;
  logic        job_wr;
  logic        pend, pend_val;
  logic        sweep_pend;
  logic        trig;
  logic [3:0]  rd_addr;
  logic        hs;
  logic        want_wr, want_sweep;

  mmap_sweep_timer #(.PERIOD(PERIOD)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (cont_mode),
    .trig (trig)
  );

  assign rd_addr    = FIRST_ADDR + idx;
  assign hs         = out_valid & out_ready;
  assign want_wr    = pend | stats_ctl_req;
  // A sweep request that lost to a write is remembered in sweep_pend and run right after it.
  assign want_sweep = start | trig | sweep_pend;

  always_comb begin
    state_nx    = state;
    bus_req     = 1'b0;
    busy        = 1'b0;
    mmap_re     = 1'b0;
    br_stats_wr = 1'b0;
    mmap_addr   = 4'h0;
    case (state)
      ST_IDLE: begin
        if (want_wr || want_sweep) state_nx = ST_REQ;
      end
      ST_REQ: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        if (bus_gnt) state_nx = job_wr ? ST_WRITE : ST_READ;
      end
      ST_READ: begin
        bus_req   = 1'b1;
        busy      = 1'b1;
        mmap_re   = bus_gnt;
        mmap_addr = rd_addr;
        state_nx  = bus_gnt ? ST_HOLD : ST_REQ;
      end
      ST_HOLD: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        if (hs) begin
          if (idx == LAST_IDX) state_nx = ST_IDLE;
          else                 state_nx = bus_gnt ? ST_READ : ST_REQ;
        end
      end
      ST_WRITE: begin
        bus_req     = 1'b1;
        busy        = 1'b1;
        br_stats_wr = bus_gnt;
        mmap_addr   = REG_STATS_EN;
        state_nx    = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign databus = br_stats_wr ? {15'b0, pend_val} : 16'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= 4'h0;
      job_wr     <= 1'b0;
      pend       <= 1'b0;
      pend_val   <= 1'b0;
      sweep_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_addr   <= 4'h0;
      out_data   <= 16'h0000;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_nx;
      sweep_done <= 1'b0;
      if (stats_ctl_req) begin
        pend     <= 1'b1;
        pend_val <= stats_ctl_val;
      end else if (state == ST_WRITE) begin
        pend <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (want_wr) begin
            job_wr     <= 1'b1;
            sweep_pend <= sweep_pend | start | trig;
          end else if (want_sweep) begin
            job_wr     <= 1'b0;
            idx        <= 4'h0;
            sweep_pend <= 1'b0;
          end
        end
        ST_READ: begin
          if (bus_gnt) begin
            out_valid <= 1'b1;
            out_addr  <= rd_addr;
            out_data  <= databus;
          end
        end
        ST_HOLD: begin
          if (hs) begin
            out_valid <= 1'b0;
            if (idx == LAST_IDX) sweep_done <= 1'b1;
            else                 idx <= idx + 4'h1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
